// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the gate BIST sequencer.
// Holds the FSM state encoding, the ID width and the truth-table lookup.
package gate_bist_pkg;

  localparam int ID_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Truth tables are passed zero-extended to 16 bits so one helper covers every N_IN.
  function automatic logic expected_bit(input logic [15:0] truth, input logic [3:0] v);
    return truth[v];
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable 8-bit down-counter that measures the settle interval.
// It stops at zero and flags that condition combinationally from the count register.
module bist_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer for a single-output combinational gate.
// Walks every input vector in ascending order and stops on the first mismatch.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 4,
  parameter logic [(1<<N_IN)-1:0]  TRUTH  = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ID_W-1:0]   case_id,
  output logic [ID_W-1:0]   fail_id
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   v_q, v_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ID_W-1:0]   case_id_q, case_id_d;
  logic [ID_W-1:0]   fail_id_q, fail_id_d;

  logic              timer_load;
  logic              timer_zero;
  logic [N_IN-1:0]   v_next;
  logic              last_vec;
  logic              exp_bit;

  bist_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (8'(SETTLE - 1)),
    .zero     (timer_zero)
  );

  // Stim, case_id and busy are updated on the transition into APPLY/DONE so they
  // are already valid during the APPLY cycle and stay stable through CHECK.
  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    case_id_d  = case_id_q;
    fail_id_d  = fail_id_q;
    timer_load = 1'b0;
    v_next     = v_q + N_IN'(1);
    last_vec   = &v_q;
    exp_bit    = expected_bit(16'(TRUTH), 4'(v_q));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d    = 1'b0;
          fail_id_d = '0;
          v_d       = '0;
          stim_d    = '0;
          case_id_d = ID_W'(1);
          busy_d    = 1'b1;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (SETTLE == 0) begin
          state_d = ST_CHECK;
        end else begin
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((resp != exp_bit) || last_vec) begin
          if (resp != exp_bit) begin
            fail_id_d = ID_W'(v_q) + ID_W'(1);
          end else begin
            pass_d = 1'b1;
          end
          busy_d  = 1'b0;
          stim_d  = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          v_d       = v_next;
          stim_d    = v_next;
          case_id_d = ID_W'(v_next) + ID_W'(1);
          state_d   = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      v_q       <= '0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      case_id_q <= '0;
      fail_id_q <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      case_id_q <= case_id_d;
      fail_id_q <= fail_id_d;
    end
  end

  assign stim    = stim_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign case_id = case_id_q;
  assign fail_id = fail_id_q;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: four instances model not/and/xor-table/no-settle cells.
// Stimulus pushes expected DONE results; a monitor pops and compares on every done pulse.
module tb_gate_bist;

  logic        clk = 1'b0;
  logic [3:0]  start_v;
  logic [3:0]  rst_v;
  logic [3:0]  resp_v;
  logic [3:0]  done_w, busy_w, pass_w;
  logic [0:0]  stim0;
  logic [1:0]  stim1, stim2, stim3;
  logic [7:0]  case_w [4];
  logic [7:0]  fail_w [4];

  int cyc      = 0;
  int run_t0   = 0;
  int resp_mode = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   inst;
    int   cyc;
    int   pass;
    int   fail_id;
    int   case_id;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: inverter. 1 is an and cell with selectable faults, 2 an and cell
  // checked against an xor table, 3 an and cell with zero settle time.
  gate_bist #(.N_IN(1), .SETTLE(4), .TRUTH(2'b01)) u_not (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stim(stim0), .resp(resp_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .case_id(case_w[0]), .fail_id(fail_w[0]));

  gate_bist #(.N_IN(2), .SETTLE(4), .TRUTH(4'b1000)) u_and (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stim(stim1), .resp(resp_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .case_id(case_w[1]), .fail_id(fail_w[1]));

  gate_bist #(.N_IN(2), .SETTLE(4), .TRUTH(4'b0110)) u_xor (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .stim(stim2), .resp(resp_v[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .case_id(case_w[2]), .fail_id(fail_w[2]));

  gate_bist #(.N_IN(2), .SETTLE(0), .TRUTH(4'b1000)) u_fast (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .stim(stim3), .resp(resp_v[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .case_id(case_w[3]), .fail_id(fail_w[3]));

  // Mode 2 drives the wrong answer everywhere except the CHECK cycles, so the
  // run only passes if resp is sampled exactly in CHECK.
  always_comb begin
    resp_v[0] = ~stim0[0];
    case (resp_mode)
      1:       resp_v[1] = 1'b1;
      2:       resp_v[1] = (((cyc - run_t0) % 6) == 0) ? (stim1[0] & stim1[1]) : ~(stim1[0] & stim1[1]);
      default: resp_v[1] = stim1[0] & stim1[1];
    endcase
    resp_v[2] = stim2[0] & stim2[1];
    resp_v[3] = stim3[0] & stim3[1];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - run_t0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_w[i]) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("unexpected_done_inst%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("done_inst", i, e.inst);
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("pass", int'(pass_w[i]), e.pass);
          checkOutput("fail_id", int'(fail_w[i]), e.fail_id);
          checkOutput("case_id", int'(case_w[i]), e.case_id);
        end
      end
    end
  end

  task automatic applyStimulus(input int inst, input int done_k, input int exp_pass,
                               input int exp_fail, input int exp_case);
    exp_t e;
    @(negedge clk);
    start_v[inst] = 1'b1;
    run_t0 = cyc;
    e = '{inst: inst, cyc: run_t0 + done_k, pass: exp_pass, fail_id: exp_fail, case_id: exp_case};
    sb.push_back(e);
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic waitCycle(input int k);
    while (cyc < run_t0 + k) @(negedge clk);
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start_v = 4'b0;
    rst_v   = 4'hF;
    repeat (3) @(negedge clk);
    rst_v = 4'h0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      checkOutput("reset_busy", int'(busy_w[i]), 0);
      checkOutput("reset_pass", int'(pass_w[i]), 0);
      checkOutput("reset_case_id", int'(case_w[i]), 0);
      checkOutput("reset_fail_id", int'(fail_w[i]), 0);
    end
    checkOutput("reset_stim", int'(stim0), 0);

    $display("[TB] not gate, full pass");
    applyStimulus(0, 13, 1, 0, 2);
    checkOutput("not_stim_v0", int'(stim0), 0);
    checkOutput("not_busy_apply", int'(busy_w[0]), 1);
    checkOutput("not_case_v0", int'(case_w[0]), 1);
    waitCycle(7);
    checkOutput("not_stim_v1", int'(stim0), 1);
    checkOutput("not_case_v1", int'(case_w[0]), 2);
    waitCycle(12);
    checkOutput("not_busy_last_check", int'(busy_w[0]), 1);
    waitCycle(13);
    checkOutput("not_stim_done", int'(stim0), 0);
    checkOutput("not_busy_done", int'(busy_w[0]), 0);
    waitIdle();
    checkOutput("not_pass_hold", int'(pass_w[0]), 1);

    $display("[TB] and cell stuck-at-1");
    resp_mode = 1;
    applyStimulus(1, 7, 0, 1, 1);
    waitIdle();

    $display("[TB] and cell correct");
    resp_mode = 0;
    applyStimulus(1, 25, 1, 0, 4);
    waitIdle();

    $display("[TB] and cell with resp wrong outside CHECK");
    resp_mode = 2;
    applyStimulus(1, 25, 1, 0, 4);
    waitIdle();
    resp_mode = 0;

    $display("[TB] and cell against xor table, first failure only");
    applyStimulus(2, 13, 0, 2, 2);
    waitIdle();
    checkOutput("xor_fail_hold", int'(fail_w[2]), 2);
    checkOutput("xor_pass_hold", int'(pass_w[2]), 0);

    $display("[TB] zero settle time");
    applyStimulus(3, 9, 1, 0, 4);
    waitCycle(2);
    checkOutput("fast_case_v0_check", int'(case_w[3]), 1);
    waitCycle(3);
    checkOutput("fast_case_v1_apply", int'(case_w[3]), 2);
    waitIdle();

    $display("[TB] reset mid-run");
    @(negedge clk);
    start_v[0] = 1'b1;
    run_t0 = cyc;
    @(negedge clk);
    start_v[0] = 1'b0;
    waitCycle(5);
    checkOutput("rst_busy_before", int'(busy_w[0]), 1);
    rst_v[0] = 1'b1;
    waitCycle(6);
    rst_v[0] = 1'b0;
    checkOutput("rst_stim", int'(stim0), 0);
    checkOutput("rst_busy", int'(busy_w[0]), 0);
    checkOutput("rst_done", int'(done_w[0]), 0);
    checkOutput("rst_pass", int'(pass_w[0]), 0);
    checkOutput("rst_case_id", int'(case_w[0]), 0);
    checkOutput("rst_fail_id", int'(fail_w[0]), 0);
    repeat (20) @(negedge clk);
    applyStimulus(0, 13, 1, 0, 2);
    waitIdle();

    // Second run starts in the IDLE cycle after DONE, i.e. 14 cycles after the first run's start.
    $display("[TB] start held high");
    @(negedge clk);
    start_v[0] = 1'b1;
    run_t0 = cyc;
    sb.push_back('{inst: 0, cyc: run_t0 + 13, pass: 1, fail_id: 0, case_id: 2});
    sb.push_back('{inst: 0, cyc: run_t0 + 14 + 13, pass: 1, fail_id: 0, case_id: 2});
    waitCycle(20);
    start_v[0] = 1'b0;
    waitIdle();
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
